// File: rtl/note_pkg.sv
// note_pkg: shared definitions for the note mixer.
//   - default channel count and bus widths
//   - mixer FSM state encoding
//   - wave_sel encoding
package note_pkg;
  localparam int NOTES_DEF = 12;
  localparam int CNT_W_DEF = 16;
  localparam int AMP_W_DEF = 8;

  localparam logic WAVE_SQUARE = 1'b0;
  localparam logic WAVE_SAW    = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} mix_state_t;
endpackage

// File: rtl/note_mixer_div.sv
// note_mixer_div: sequential restoring divider, one quotient bit per cycle.
//   clk, n_rst : clock, async active-low reset
//   start      : 1-cycle pulse; operands are loaded and the first bit is
//                resolved on the same edge
//   dividend   : DVD_W-bit numerator
//   divisor    : DVS_W-bit denominator (must be non-zero)
//   quo        : quotient, stable from the cycle done is high
//   done       : 1-cycle pulse, first cycle in which quo is final
// start to done is DVD_W cycles.
module note_mixer_div #(
  parameter int DVD_W = 12,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quo,
  output logic             done
);
  localparam int CW = $clog2(DVD_W);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             run;

  // One restoring step: shift the next dividend bit into the remainder,
  // subtract when it fits. The remainder always stays below the divisor,
  // so DVS_W bits suffice after the subtract.
  function automatic logic [DVS_W+DVD_W-1:0] step(
    input logic [DVS_W-1:0] r,
    input logic [DVD_W-1:0] q,
    input logic [DVS_W-1:0] d
  );
    logic [DVS_W:0] trial;
    trial = {r, q[DVD_W-1]};
    if (trial >= {1'b0, d}) begin
      trial = trial - {1'b0, d};
      step  = {trial[DVS_W-1:0], q[DVD_W-2:0], 1'b1};
    end else begin
      step  = {trial[DVS_W-1:0], q[DVD_W-2:0], 1'b0};
    end
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, quo} <= step('0, dividend, divisor);
        dvs        <= divisor;
        cnt        <= CW'(DVD_W - 1);
        run        <= 1'b1;
      end else if (run) begin
        {rem, quo} <= step(rem, quo, dvs);
        cnt        <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/note_mixer.sv
// note_mixer: turns per-note divider count/limit pairs into waveform levels,
// sums the levels of the pressed keys and divides by the number of pressed
// keys, producing one AMP_W-bit sample per sample_tick.
//   clk, n_rst   : clock, async active-low reset
//   cnt_bus      : NOTES x CNT_W divider counts, note i at [i*CNT_W +: CNT_W]
//   lim_bus      : NOTES x CNT_W divider limits, same packing
//   key_en       : per-note key pressed
//   wave_sel     : 0 square, 1 saw (saw only with NOTE_MIXER_SAW_EN)
//   sample_tick  : request a new sample (accepted only in IDLE)
//   sample       : mixed sample, held between updates
//   sample_valid : 1-cycle strobe when sample updates
//   busy         : tick accepted, sample not yet delivered
//   overrun      : sticky, a tick arrived while busy
// Build option: define NOTE_MIXER_SAW_EN to enable the saw waveform;
// otherwise wave_sel is ignored and every note is square.
// Timing: tick accepted in cycle T -> sample_valid in T+26 (T+14 when no
// key is pressed).
module note_mixer
  import note_pkg::*;
#(
  parameter int NOTES = NOTES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int AMP_W = AMP_W_DEF
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NOTES*CNT_W-1:0] cnt_bus,
  input  logic [NOTES*CNT_W-1:0] lim_bus,
  input  logic [NOTES-1:0]       key_en,
  input  logic                   wave_sel,
  input  logic                   sample_tick,
  output logic [AMP_W-1:0]       sample,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   overrun
);
  localparam int SUM_W = AMP_W + 4;
  localparam int ACT_W = 4;
  localparam int IDX_W = $clog2(NOTES + 1);
  localparam int CLZ_W = $clog2(CNT_W + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NOTES);

  mix_state_t state;
  logic [IDX_W-1:0] idx;
  logic [NOTES-1:0] keys_q;
  logic [SUM_W-1:0] sum;
  logic [ACT_W-1:0] act;
  logic [AMP_W-1:0] lvl_q;
  logic             hit_q;
  logic             wave_eff;

  logic [NOTES-1:0][CNT_W-1:0] cnt_arr, lim_arr;
  assign cnt_arr = cnt_bus;
  assign lim_arr = lim_bus;

`ifdef NOTE_MIXER_SAW_EN
  logic wave_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                           wave_q <= WAVE_SQUARE;
    else if (state == IDLE && sample_tick) wave_q <= wave_sel;
  end
  assign wave_eff = wave_q;
`else
  logic wave_sel_unused;
  assign wave_sel_unused = wave_sel;
  assign wave_eff        = WAVE_SQUARE;
`endif

  function automatic logic [CLZ_W-1:0] clz_f(input logic [CNT_W-1:0] v);
    logic found;
    found = 1'b0;
    clz_f = CLZ_W'(CNT_W);
    for (int b = CNT_W - 1; b >= 0; b--) begin
      if (!found && v[b]) begin
        clz_f = CLZ_W'(CNT_W - 1 - b);
        found = 1'b1;
      end
    end
  endfunction

  // Square: high for the first half of the divider period (lim=0 -> high).
  // Saw: normalise the count so the limit's MSB lands on bit CNT_W-1, then
  // take the top AMP_W bits (lim=0 -> 0).
  function automatic logic [AMP_W-1:0] level_f(
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] l,
    input logic             w
  );
    logic [CNT_W-1:0] shl;
    shl     = '0;
    level_f = '0;
    if (w == WAVE_SAW) begin
      if (l != '0) begin
        shl     = c << clz_f(l);
        level_f = shl[CNT_W-1 -: AMP_W];
      end
    end else if (l == '0 || c <= (l >> 1)) begin
      level_f = '1;
    end
  endfunction

  // The note level is registered in its own ACCUM cycle and added one cycle
  // later, so ACCUM takes NOTES+1 cycles; idx==LAST is the drain cycle.
  logic [IDX_W-1:0] sel;
  logic [AMP_W-1:0] lvl;
  logic [SUM_W-1:0] sum_nxt;
  logic [ACT_W-1:0] act_nxt;

  assign sel     = (idx < LAST) ? idx : '0;
  assign lvl     = level_f(cnt_arr[sel], lim_arr[sel], wave_eff);
  assign sum_nxt = sum + (hit_q ? SUM_W'(lvl_q) : '0);
  assign act_nxt = act + ACT_W'(hit_q);

  logic             div_start;
  logic [SUM_W-1:0] div_quo;
  logic             div_done;
  logic [SUM_W-AMP_W-1:0] quo_hi_unused;

  assign div_start     = (state == ACCUM) && (idx == LAST) && (act_nxt != '0);
  assign quo_hi_unused = div_quo[SUM_W-1:AMP_W];

  note_mixer_div #(.DVD_W(SUM_W), .DVS_W(ACT_W)) u_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (div_start),
    .dividend (sum_nxt),
    .divisor  (act_nxt),
    .quo      (div_quo),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      idx          <= '0;
      keys_q       <= '0;
      sum          <= '0;
      act          <= '0;
      lvl_q        <= '0;
      hit_q        <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_tick) begin
          keys_q <= key_en;
          sum    <= '0;
          act    <= '0;
          hit_q  <= 1'b0;
          idx    <= '0;
          busy   <= 1'b1;
          state  <= ACCUM;
        end
        ACCUM: begin
          lvl_q <= lvl;
          hit_q <= (idx < LAST) && keys_q[sel];
          sum   <= sum_nxt;
          act   <= act_nxt;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            if (act_nxt == '0) begin
              sample       <= '0;
              sample_valid <= 1'b1;
              state        <= OUT;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: if (div_done) begin
          sample       <= div_quo[AMP_W-1:0];
          sample_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
